// File: rtl/bc_pkg.sv
// Shared constants for the Bulls & Cows display path.
package bc_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;
    localparam logic [3:0] SYM_B     = 4'hB;
    localparam logic [3:0] SYM_C     = 4'hC;
endpackage

// File: rtl/bc_hex7seg.sv
// Hex symbol to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module bc_hex7seg (
    input  logic [3:0] sym_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'h7F;
        case (sym_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'h7F;
        endcase
    end
endmodule

// File: rtl/bc_display_scan.sv
// 8-digit multiplexed 7-segment scanner with frame-aligned double buffering and blink.
module bc_display_scan
    import bc_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        update,
    input  logic [31:0] data_in,
    input  logic [7:0]  blank_in,
    input  logic [7:0]  blink_in,
    output logic        upd_pending,
    output logic        frame_tick,
    output logic [7:0]  an,
    output logic [6:0]  digit
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_TC  = CW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BCNT_TC = BW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [31:0]   act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [7:0]    act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic [7:0]    act_blink_q, act_blink_d, pend_blink_q, pend_blink_d;
    logic          pend_vld_q, pend_vld_d;
    logic          tick_q, tick_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    dig_q, dig_d;

    logic          cnt_tc, boundary, lit;
    logic [3:0]    sym;
    logic [6:0]    seg;

    assign cnt_tc   = (cnt_q == CNT_TC);
    assign boundary = cnt_tc && (idx_q == 3'd7);
    assign sym      = act_data_q[idx_q*4 +: 4];
    assign lit      = !act_blank_q[idx_q] && !(act_blink_q[idx_q] && !phase_q);

    bc_hex7seg u_hex (.sym_i(sym), .seg_o(seg));

    always_comb begin
        cnt_d        = cnt_tc ? '0 : cnt_q + 1'b1;
        idx_d        = cnt_tc ? idx_q + 3'd1 : idx_q;
        bcnt_d       = (bcnt_q == BCNT_TC) ? '0 : bcnt_q + 1'b1;
        phase_d      = (bcnt_q == BCNT_TC) ? !phase_q : phase_q;
        act_data_d   = act_data_q;
        act_blank_d  = act_blank_q;
        act_blink_d  = act_blink_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_blink_d = pend_blink_q;
        pend_vld_d   = pend_vld_q;
        // An update landing on the boundary bypasses the pending buffer.
        if (boundary) begin
            if (update) begin
                act_data_d  = data_in;
                act_blank_d = blank_in;
                act_blink_d = blink_in;
            end else if (pend_vld_q) begin
                act_data_d  = pend_data_q;
                act_blank_d = pend_blank_q;
                act_blink_d = pend_blink_q;
            end
            pend_vld_d = 1'b0;
        end else if (update) begin
            pend_data_d  = data_in;
            pend_blank_d = blank_in;
            pend_blink_d = blink_in;
            pend_vld_d   = 1'b1;
        end
        // Look ahead one cycle so the tick is flopped yet aligned with the boundary.
        tick_d = (cnt_d == CNT_TC) && (idx_d == 3'd7);
        an_d   = lit ? ~(8'b1 << idx_q) : AN_OFF;
        dig_d  = lit ? seg : SEG_BLANK;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            bcnt_q       <= '0;
            phase_q      <= 1'b1;
            act_data_q   <= '0;
            act_blank_q  <= 8'hFF;
            act_blink_q  <= '0;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            pend_blink_q <= '0;
            pend_vld_q   <= 1'b0;
            tick_q       <= 1'b0;
            an_q         <= AN_OFF;
            dig_q        <= SEG_BLANK;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            bcnt_q       <= bcnt_d;
            phase_q      <= phase_d;
            act_data_q   <= act_data_d;
            act_blank_q  <= act_blank_d;
            act_blink_q  <= act_blink_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_blink_q <= pend_blink_d;
            pend_vld_q   <= pend_vld_d;
            tick_q       <= tick_d;
            an_q         <= an_d;
            dig_q        <= dig_d;
        end
    end

    assign upd_pending = pend_vld_q;
    assign frame_tick  = tick_q;
    assign an          = an_q;
    assign digit       = dig_q;
endmodule

// File: tb/tb_bc_display_scan.sv
// Randomized bench for bc_display_scan against a cycle-indexed behavioural model.
module tb_bc_display_scan;
    localparam int R = 4;
    localparam int B = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        update = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  blank_in = '0;
    logic [7:0]  blink_in = '0;
    logic        upd_pending, frame_tick;
    logic [7:0]  an;
    logic [6:0]  digit;

    bc_display_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clock(clock), .reset(reset), .update(update), .data_in(data_in),
        .blank_in(blank_in), .blink_in(blink_in), .upd_pending(upd_pending),
        .frame_tick(frame_tick), .an(an), .digit(digit)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: m_t counts cycles since reset release; scan position and blink
    // phase follow from it arithmetically.
    int          m_t;
    logic [31:0] a_data, p_data;
    logic [7:0]  a_blank, a_blink, p_blank, p_blink;
    logic        p_vld;
    logic [7:0]  e_an;
    logic [6:0]  e_dig;

    task automatic model_reset();
        m_t = 0;
        a_data = '0; a_blank = 8'hFF; a_blink = '0;
        p_data = '0; p_blank = '0; p_blink = '0; p_vld = 1'b0;
        e_an = 8'hFF; e_dig = 7'h7F;
    endtask

    // Called at a negedge; leaves the bench at a later negedge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            int   idx;
            logic phase, lit, bnd;
            bnd   = (m_t % (8 * R)) == (8 * R - 1);
            idx   = (m_t / R) % 8;
            phase = ((m_t / B) % 2) == 0;
            chk("frame_tick", {31'd0, frame_tick}, {31'd0, bnd});
            chk("upd_pending", {31'd0, upd_pending}, {31'd0, p_vld});
            chk("an", {24'd0, an}, {24'd0, e_an});
            chk("digit", {25'd0, digit}, {25'd0, e_dig});
            chk("an_onehot", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);

            update   = bnd ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            data_in  = $urandom;
            blank_in = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            blink_in = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);

            lit   = !a_blank[idx] && !(a_blink[idx] && !phase);
            e_an  = lit ? ~(8'h01 << idx) : 8'hFF;
            e_dig = lit ? hex_tab[a_data[idx*4 +: 4]] : 7'h7F;
            if (bnd) begin
                if (update) begin
                    a_data = data_in; a_blank = blank_in; a_blink = blink_in;
                end else if (p_vld) begin
                    a_data = p_data; a_blank = p_blank; a_blink = p_blink;
                end
                p_vld = 1'b0;
            end else if (update) begin
                p_data = data_in; p_blank = blank_in; p_blink = blink_in;
                p_vld = 1'b1;
            end
            m_t++;
            @(negedge clock);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("rst_an", {24'd0, an}, 32'hFF);
            chk("rst_digit", {25'd0, digit}, 32'h7F);
            chk("rst_pending", {31'd0, upd_pending}, 32'd0);
            chk("rst_tick", {31'd0, frame_tick}, 32'd0);
        end
        reset = 1'b0;
        model_reset();
        run(3000);

        @(posedge clock);
        #2;
        reset  = 1'b1;
        update = 1'b0;
        #1;
        chk("async_an", {24'd0, an}, 32'hFF);
        chk("async_digit", {25'd0, digit}, 32'h7F);
        chk("async_pending", {31'd0, upd_pending}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        run(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
